// File: rtl/gessm_pipe.sv
// gessm_pipe: approximate unsigned multiplier that multiplies M-bit operand segments and shifts the product back to 2N bits.
// Latency: 3 cycles from input transfer to out_valid, 1 result/cycle.
// Backpressure: per-stage valid bits with bubble collapse; in_ready = en1, combinational on out_ready.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/a/b operand side; out_valid/out_ready/ris result side.
// Optional macro GESSM_BIAS_EN: widens truncated segments with a half-LSB bias bit to reduce mean error.
module gessm_pipe #(
    parameter int N = 16,
    parameter int M = 10,
    parameter int Q = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] ris
);

`ifdef GESSM_BIAS_EN
    localparam int OW = M + 1;
`else
    localparam int OW = M;
`endif
    localparam int PW = 2 * OW;
    localparam int RW = 2 * N;
    localparam int SW = $clog2(RW);

    // Returns {code, segment}; code 2'b1x = offset N-M, 2'b01 = offset Q, 2'b00 = offset 0.
    function automatic logic [M+1:0] select(input logic [N-1:0] x);
        if (|x[N-1:M+Q])
            return {2'b10, x[N-1:N-M]};
        else if (|x[M+Q-1:M])
            return {2'b01, x[M+Q-1:Q]};
        else
            return {2'b00, x[M-1:0]};
    endfunction

    // Shift applied to the product for one operand's segment code.
    function automatic logic [SW-1:0] shamt(input logic [1:0] code);
`ifdef GESSM_BIAS_EN
        // The appended bias bit already supplies one bit of weight.
        if (code[1])
            return SW'(N - M - 1);
        else if (code[0])
            return SW'(Q - 1);
        else
            return '0;
`else
        if (code[1])
            return SW'(N - M);
        else if (code[0])
            return SW'(Q);
        else
            return '0;
`endif
    endfunction

    logic          v1, v2, v3;
    logic          en1, en2, en3;
    logic [M+1:0]  sel_a, sel_b;
    logic [OW-1:0] op_a, op_b;
    logic [OW-1:0] op1_a, op1_b;
    logic [1:0]    c1_a, c1_b, c2_a, c2_b;
    logic [PW-1:0] p2;
    logic [RW-1:0] ris_q;

    assign en3       = out_ready | ~v3;
    assign en2       = en3 | ~v2;
    assign en1       = en2 | ~v1;
    assign in_ready  = en1;
    assign out_valid = v3;
    assign ris       = ris_q;

    assign sel_a = select(a);
    assign sel_b = select(b);

`ifdef GESSM_BIAS_EN
    assign op_a = (sel_a[M+1:M] != 2'b00) ? {sel_a[M-1:0], 1'b1} : {1'b0, sel_a[M-1:0]};
    assign op_b = (sel_b[M+1:M] != 2'b00) ? {sel_b[M-1:0], 1'b1} : {1'b0, sel_b[M-1:0]};
`else
    assign op_a = sel_a[M-1:0];
    assign op_b = sel_b[M-1:0];
`endif

    // Valid bits: a stage takes its upstream valid whenever it is enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
        end
    end

    // Stage 1: segment selection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_a <= '0;
            op1_b <= '0;
            c1_a  <= '0;
            c1_b  <= '0;
        end else if (en1 && in_valid) begin
            op1_a <= op_a;
            op1_b <= op_b;
            c1_a  <= sel_a[M+1:M];
            c1_b  <= sel_b[M+1:M];
        end
    end

    // Stage 2: segment product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p2   <= '0;
            c2_a <= '0;
            c2_b <= '0;
        end else if (en2 && v1) begin
            p2   <= PW'(op1_a) * PW'(op1_b);
            c2_a <= c1_a;
            c2_b <= c1_b;
        end
    end

    // Stage 3: shift back; the total shift never pushes bits past RW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ris_q <= '0;
        end else if (en3 && v2) begin
            ris_q <= RW'(p2) << (shamt(c2_a) + shamt(c2_b));
        end
    end

endmodule
